nn_weight_loader: RTL and testbench

- Initiator side of the neuron configuration write interface.
- Accepts a host word stream (valid/ready) and drives the write bus into every neuron of a layer: weightValid, biasValid, weightValue, biasValue, config_layer_num, config_neuron_num.
- Per neuron, the stream carries one bias word followed by numWeight weight words.
- Sits between the DMA/host FIFO and the layer array; one instance serves all layers.

---
 rtl/nn_weight_loader_pkg.sv | 23 ++
 rtl/nn_loader_outreg.sv | 60 ++++++
 rtl/nn_weight_loader.sv | 173 +++++++++++++++++
 tb/tb_nn_weight_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_weight_loader_pkg.sv
// nn_weight_loader_pkg
// Shared definitions for the neuron weight loader: state encoding and
// counter-width helper used to size the neuron/weight counters.
package nn_weight_loader_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BIAS   = 2'd1;
  localparam logic [1:0] WEIGHT = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_BIAS   = BIAS,
    ST_WEIGHT = WEIGHT,
    ST_DONE   = DONE
  } state_t;

  // Bits needed to hold any value 0..max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/nn_loader_outreg.sv
// nn_loader_outreg
// Registered write-bus stage of the weight loader. One cycle after an
// accepted word it pulses the matching strobe and presents the word, layer
// and neuron number. Value/number outputs hold while strobes are low.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   abort                 suppresses any strobe registered this cycle
//   bias_acc, weight_acc  bias / weight word accepted this cycle
//   word                  accepted stream word
//   layer, neuron         target layer / neuron for the accepted word
//   weightValid, biasValid, weightValue, biasValue,
//   config_layer_num, config_neuron_num   write bus into the layer array
module nn_loader_outreg
  import nn_weight_loader_pkg::*;
#(
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 abort,
  input  logic                 bias_acc,
  input  logic                 weight_acc,
  input  logic [dataWidth-1:0] word,
  input  logic [31:0]          layer,
  input  logic [31:0]          neuron,
  output logic                 weightValid,
  output logic                 biasValid,
  output logic [dataWidth-1:0] weightValue,
  output logic [dataWidth-1:0] biasValue,
  output logic [31:0]          config_layer_num,
  output logic [31:0]          config_neuron_num
);

  logic bias_wr;
  logic weight_wr;

  assign bias_wr   = bias_acc & ~abort;
  assign weight_wr = weight_acc & ~abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weightValid       <= 1'b0;
      biasValid         <= 1'b0;
      weightValue       <= '0;
      biasValue         <= '0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
    end else begin
      biasValid   <= bias_wr;
      weightValid <= weight_wr;
      if (bias_wr) biasValue <= word;
      if (weight_wr) weightValue <= word;
      if (bias_wr | weight_wr) begin
        config_layer_num  <= layer;
        config_neuron_num <= neuron;
      end
    end
  end

endmodule

// File: rtl/nn_weight_loader.sv
// nn_weight_loader
// Initiator of the neuron configuration write interface. Consumes a host
// word stream (one bias then cfg_num_weights weights per neuron) and drives
// the layer write bus through nn_loader_outreg.
// Optional feature macro: NN_LOADER_CHECKSUM_EN (32-bit sum of accepted
// words, sign-extended); when undefined checksum is tied to 0.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   start, abort                       launch / cancel a load
//   cfg_layer, cfg_num_neurons,
//   cfg_num_weights                    load setup, sampled at start
//   s_data, s_valid, s_ready           host stream
//   weightValid, biasValid, weightValue, biasValue,
//   config_layer_num, config_neuron_num  layer write bus
//   busy, done, checksum               status
module nn_weight_loader
  import nn_weight_loader_pkg::*;
#(
  parameter int dataWidth  = 16,
  parameter int maxNeurons = 1024,
  parameter int maxWeights = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [31:0]          cfg_layer,
  input  logic [31:0]          cfg_num_neurons,
  input  logic [31:0]          cfg_num_weights,
  input  logic [dataWidth-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 weightValid,
  output logic                 biasValid,
  output logic [dataWidth-1:0] weightValue,
  output logic [dataWidth-1:0] biasValue,
  output logic [31:0]          config_layer_num,
  output logic [31:0]          config_neuron_num,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          checksum
);

  localparam int NW = cnt_width(maxNeurons);
  localparam int WW = cnt_width(maxWeights);
  localparam logic [NW-1:0] N_ONE = 1;
  localparam logic [WW-1:0] W_ONE = 1;

  state_t        state, state_nxt;
  logic [31:0]   layer_q;
  logic [NW-1:0] num_n_q, n_q, n_nxt;
  logic [WW-1:0] num_w_q, k_q, k_nxt;
  logic          done_q;
  logic          accept, load, empty_cfg, last_w, last_n;
  logic          bias_acc, weight_acc;

  assign s_ready    = ((state == ST_BIAS) || (state == ST_WEIGHT)) && !abort;
  assign accept     = s_valid & s_ready;
  assign load       = (state == ST_IDLE) && start && !abort;
  assign empty_cfg  = (cfg_num_neurons == 32'd0) || (cfg_num_weights == 32'd0);
  assign bias_acc   = accept && (state == ST_BIAS);
  assign weight_acc = accept && (state == ST_WEIGHT);
  assign last_w     = (k_q == (num_w_q - W_ONE));
  assign last_n     = (n_q == (num_n_q - N_ONE));

  always_comb begin
    state_nxt = state;
    n_nxt     = n_q;
    k_nxt     = k_q;
    case (state)
      ST_IDLE: begin
        if (load) begin
          n_nxt     = '0;
          k_nxt     = '0;
          state_nxt = empty_cfg ? ST_DONE : ST_BIAS;
        end
      end
      ST_BIAS: begin
        if (accept) state_nxt = ST_WEIGHT;
      end
      ST_WEIGHT: begin
        if (accept) begin
          if (last_w) begin
            k_nxt = '0;
            if (last_n) begin
              state_nxt = ST_DONE;
            end else begin
              n_nxt     = n_q + N_ONE;
              state_nxt = ST_BIAS;
            end
          end else begin
            k_nxt = k_q + W_ONE;
          end
        end
      end
      ST_DONE: begin
        n_nxt     = '0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
      n_nxt     = '0;
      k_nxt     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      layer_q <= '0;
      num_n_q <= '0;
      num_w_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      n_q    <= n_nxt;
      k_q    <= k_nxt;
      // done trails the DONE state by one cycle, so it lands one cycle after
      // the last weight strobe (and two cycles after start for an empty load)
      done_q <= (state == ST_DONE) && !abort;
      if (load) begin
        layer_q <= cfg_layer;
        num_n_q <= cfg_num_neurons[NW-1:0];
        num_w_q <= cfg_num_weights[WW-1:0];
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = done_q;

  nn_loader_outreg #(
    .dataWidth(dataWidth)
  ) u_outreg (
    .clk              (clk),
    .rst_n            (rst_n),
    .abort            (abort),
    .bias_acc         (bias_acc),
    .weight_acc       (weight_acc),
    .word             (s_data),
    .layer            (layer_q),
    .neuron           ({{(32-NW){1'b0}}, n_q}),
    .weightValid      (weightValid),
    .biasValid        (biasValid),
    .weightValue      (weightValue),
    .biasValue        (biasValue),
    .config_layer_num (config_layer_num),
    .config_neuron_num(config_neuron_num)
  );

`ifdef NN_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (abort || load) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + {{(32-dataWidth){s_data[dataWidth-1]}}, s_data};
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_nn_weight_loader.sv
module tb_nn_weight_loader;

`ifdef NN_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_layer = '0;
  logic [31:0] cfg_num_neurons = '0;
  logic [31:0] cfg_num_weights = '0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        weightValid, biasValid;
  logic [15:0] weightValue, biasValue;
  logic [31:0] config_layer_num, config_neuron_num;
  logic        busy, done;
  logic [31:0] checksum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nn_weight_loader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .cfg_layer        (cfg_layer),
    .cfg_num_neurons  (cfg_num_neurons),
    .cfg_num_weights  (cfg_num_weights),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .weightValid      (weightValid),
    .biasValid        (biasValid),
    .weightValue      (weightValue),
    .biasValue        (biasValue),
    .config_layer_num (config_layer_num),
    .config_neuron_num(config_neuron_num),
    .busy             (busy),
    .done             (done),
    .checksum         (checksum)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        start, abort, valid;
    logic [15:0] data;
    logic [31:0] lay;
    logic        rdy, bv, wv, busy, done;
    logic [15:0] bval, wval;
    logic [31:0] neu, layo, ck;
  } vec_t;

  vec_t tv[8];

  // Generic load: checks every strobe against the stream position of the
  // word that produced it (bias when idx % (nw+1) == 0).
  task automatic run_load(input int nn, input int nw, input logic [31:0] lay,
                          input bit stall, input int abort_at);
    int total, widx, pend, post;
    bit done_due, aborted, fin;
    logic [15:0] base;
    base = 16'h0100;
    total = nn * (nw + 1);
    widx = 0; pend = -1; post = 0;
    done_due = 0; aborted = 0; fin = 0;
    @(negedge clk);
    cfg_layer = lay; cfg_num_neurons = nn; cfg_num_weights = nw;
    start = 1; abort = 0; s_valid = 0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      start = 0;
      abort = 0;
      if (pend >= 0) begin
        if (pend % (nw + 1) == 0) begin
          chk("bias strobe", biasValid, 1);
          chk("no wv on bias", weightValid, 0);
          chk("bias value", biasValue, base + pend);
        end else begin
          chk("weight strobe", weightValid, 1);
          chk("no bv on weight", biasValid, 0);
          chk("weight value", weightValue, base + pend);
        end
        chk("neuron num", config_neuron_num, pend / (nw + 1));
        chk("layer num", config_layer_num, lay);
      end else begin
        chk("quiet bv", biasValid, 0);
        chk("quiet wv", weightValid, 0);
      end
      if (done_due) begin
        chk("done pulse", done, 1);
        chk("busy at done", busy, 0);
        fin = 1;
      end else begin
        chk("no done", done, 0);
        chk("busy", busy, !aborted);
      end
      if (total == 0 && cyc == 0) done_due = 1;
      else if (total > 0 && pend == total - 1) done_due = 1;
      if (aborted) begin
        post++;
        if (post >= 4) fin = 1;
      end
      pend = -1;
      if (!aborted && widx < total && abort_at == widx) begin
        abort = 1; s_valid = 1; s_data = 16'hDEAD; aborted = 1;
      end else if (!aborted && widx < total) begin
        s_valid = stall ? (cyc % 2 == 1) : 1'b1;
        s_data = base + widx[15:0];
      end else begin
        s_valid = 0;
      end
      #1;
      chk("s_ready", s_ready, (!aborted && widx < total));
      if (s_valid && s_ready) begin
        pend = widx;
        widx++;
      end
    end
    chk("load finished in budget", fin, 1);
    s_valid = 0;
    abort = 0;
  endtask

  initial begin
    tv[0] = '{1,0,0,16'h0000,32'd5, 1,0,0,1,0, 16'h0000,16'h0000, 32'd0,32'd0,32'h0};
    tv[1] = '{0,0,1,16'hFFFF,32'd5, 1,1,0,1,0, 16'hFFFF,16'h0000, 32'd0,32'd5,32'hFFFFFFFF};
    tv[2] = '{1,0,0,16'h0000,32'd9, 1,0,0,1,0, 16'hFFFF,16'h0000, 32'd0,32'd5,32'hFFFFFFFF};
    tv[3] = '{0,0,1,16'h0001,32'd9, 1,0,1,1,0, 16'hFFFF,16'h0001, 32'd0,32'd5,32'h0};
    tv[4] = '{0,0,1,16'h0003,32'd9, 0,0,1,1,0, 16'hFFFF,16'h0003, 32'd0,32'd5,32'h3};
    tv[5] = '{0,0,1,16'h7777,32'd9, 0,0,0,0,1, 16'hFFFF,16'h0003, 32'd0,32'd5,32'h3};
    tv[6] = '{1,1,0,16'h0000,32'd9, 0,0,0,0,0, 16'hFFFF,16'h0003, 32'd0,32'd5,32'h0};
    tv[7] = '{0,0,0,16'h0000,32'd9, 0,0,0,0,0, 16'hFFFF,16'h0003, 32'd0,32'd5,32'h0};

    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset s_ready", s_ready, 0);
    chk("reset bv", biasValid, 0);
    chk("reset wv", weightValid, 0);
    chk("reset checksum", checksum, 0);
    @(negedge clk);
    rst_n = 1;

    // 1 neuron, 2 weights, one stall, start-while-busy and start+abort
    cfg_num_neurons = 1;
    cfg_num_weights = 2;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      start = tv[i].start; abort = tv[i].abort; s_valid = tv[i].valid;
      s_data = tv[i].data; cfg_layer = tv[i].lay;
      @(negedge clk);
      chk($sformatf("v%0d s_ready", i), s_ready, tv[i].rdy);
      chk($sformatf("v%0d biasValid", i), biasValid, tv[i].bv);
      chk($sformatf("v%0d weightValid", i), weightValid, tv[i].wv);
      chk($sformatf("v%0d busy", i), busy, tv[i].busy);
      chk($sformatf("v%0d done", i), done, tv[i].done);
      chk($sformatf("v%0d biasValue", i), biasValue, tv[i].bval);
      chk($sformatf("v%0d weightValue", i), weightValue, tv[i].wval);
      chk($sformatf("v%0d neuron", i), config_neuron_num, tv[i].neu);
      chk($sformatf("v%0d layer", i), config_layer_num, tv[i].layo);
      chk($sformatf("v%0d checksum", i), checksum, CK_EN ? tv[i].ck : 32'h0);
    end
    start = 0; abort = 0; s_valid = 0;

    run_load(3, 4, 32'd2, 1'b0, -1);   // continuous stream
    run_load(3, 4, 32'd2, 1'b1, -1);   // valid on alternate cycles
    run_load(3, 4, 32'd2, 1'b0, 6);    // abort after 6 words
    run_load(2, 3, 32'd7, 1'b0, -1);   // reload from neuron 0 bias
    run_load(0, 4, 32'd3, 1'b0, -1);   // empty load

    // asynchronous reset mid-WEIGHT
    @(negedge clk);
    cfg_layer = 32'd4; cfg_num_neurons = 1; cfg_num_weights = 4; start = 1;
    @(negedge clk);
    start = 0; s_valid = 1; s_data = 16'h0055;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst weightValid", weightValid, 0);
    chk("arst biasValid", biasValid, 0);
    chk("arst weightValue", weightValue, 0);
    chk("arst biasValue", biasValue, 0);
    chk("arst layer", config_layer_num, 0);
    chk("arst neuron", config_neuron_num, 0);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst s_ready", s_ready, 0);
    chk("arst checksum", checksum, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post-reset busy", busy, 0);
    chk("post-reset s_ready", s_ready, 0);
    chk("post-reset wv", weightValid, 0);
    s_valid = 0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
